axi_lite_addr_router: RTL and testbench

Parameterised AXI4-Lite 1-to-N address router. It sits between a single AXI4-Lite master and N register-space slaves (DCM, PNS, HSM, REG, I3C, FIFO, DMA windows). Each transaction is decoded against a per-slave base/range table and forwarded to the matching slave. Addresses that hit no region are completed internally with DECERR and counted. This replaces the fixed address-map constants with a runtime-correct, range-checked decoder.

---
 rtl/axi_lite_addr_router.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_axi_lite_addr_router.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_addr_router.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_addr_router
// Brief    : AXI4-Lite 1-to-N address router with base/range decode, internal
//            DECERR completion for unmapped addresses and saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_addr_router #(
  parameter int                        N_SLV      = 4,
  parameter int                        ADDR_W     = 64,
  parameter int                        DATA_W     = 32,
  parameter logic [N_SLV*ADDR_W-1:0]   BASE_ADDRS = {64'h0000020201030000, 64'h0000020201020000,
                                                     64'h0000020201010000, 64'h0000020201000000},
  parameter logic [N_SLV*ADDR_W-1:0]   RANGES     = {4{64'h10000}},
  parameter int                        CNT_W      = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  // upstream write address / data / response
  input  logic [ADDR_W-1:0]           s_awaddr,
  input  logic                        s_awvalid,
  output logic                        s_awready,
  input  logic [DATA_W-1:0]           s_wdata,
  input  logic [DATA_W/8-1:0]         s_wstrb,
  input  logic                        s_wvalid,
  output logic                        s_wready,
  output logic [1:0]                  s_bresp,
  output logic                        s_bvalid,
  input  logic                        s_bready,
  // upstream read address / data
  input  logic [ADDR_W-1:0]           s_araddr,
  input  logic                        s_arvalid,
  output logic                        s_arready,
  output logic [DATA_W-1:0]           s_rdata,
  output logic [1:0]                  s_rresp,
  output logic                        s_rvalid,
  input  logic                        s_rready,
  // per-slave write channels
  output logic [N_SLV*ADDR_W-1:0]     m_awaddr,
  output logic [N_SLV-1:0]            m_awvalid,
  input  logic [N_SLV-1:0]            m_awready,
  output logic [N_SLV*DATA_W-1:0]     m_wdata,
  output logic [N_SLV*DATA_W/8-1:0]   m_wstrb,
  output logic [N_SLV-1:0]            m_wvalid,
  input  logic [N_SLV-1:0]            m_wready,
  input  logic [N_SLV*2-1:0]          m_bresp,
  input  logic [N_SLV-1:0]            m_bvalid,
  output logic [N_SLV-1:0]            m_bready,
  // per-slave read channels
  output logic [N_SLV*ADDR_W-1:0]     m_araddr,
  output logic [N_SLV-1:0]            m_arvalid,
  input  logic [N_SLV-1:0]            m_arready,
  input  logic [N_SLV*DATA_W-1:0]     m_rdata,
  input  logic [N_SLV*2-1:0]          m_rresp,
  input  logic [N_SLV-1:0]            m_rvalid,
  output logic [N_SLV-1:0]            m_rready,
  // DECERR statistics
  output logic [CNT_W-1:0]            wr_decerr_cnt,
  output logic [CNT_W-1:0]            rd_decerr_cnt
);

  localparam int               SEL_W     = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int               STRB_W    = DATA_W / 8;
  localparam logic [1:0]       C_DECERR  = 2'b11;
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } r_state_t;

  // Result is {miss, sel}; the limit is one bit wider so a region ending at 2^ADDR_W is valid.
  function automatic logic [SEL_W:0] f_decode(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W:0] w_base;
    logic [ADDR_W:0] w_lim;
    logic [SEL_W:0]  w_res;
    w_res = {1'b1, {SEL_W{1'b0}}};
    // Descending scan so the lowest matching index is the last one written.
    for (int i = N_SLV - 1; i >= 0; i--) begin
      w_base = {1'b0, BASE_ADDRS[i*ADDR_W +: ADDR_W]};
      w_lim  = w_base + {1'b0, RANGES[i*ADDR_W +: ADDR_W]};
      if (({1'b0, addr} >= w_base) && ({1'b0, addr} < w_lim)) begin
        w_res = {1'b0, SEL_W'(i)};
      end
    end
    return w_res;
  endfunction

  w_state_t          r_wstate, w_wstate_nxt;
  r_state_t          r_rstate, w_rstate_nxt;
  logic              r_rdy_en;
  logic [ADDR_W-1:0] r_awaddr, r_araddr;
  logic [SEL_W-1:0]  r_wsel, r_rsel;
  logic              r_wmiss, r_rmiss;
  logic [CNT_W-1:0]  r_wr_cnt, r_rd_cnt;

  logic [SEL_W:0]    w_aw_dec, w_ar_dec;
  logic              w_sel_awready, w_sel_wready, w_sel_bvalid;
  logic [1:0]        w_sel_bresp;
  logic              w_sel_arready, w_sel_rvalid;
  logic [1:0]        w_sel_rresp;
  logic [DATA_W-1:0] w_sel_rdata;

  assign w_aw_dec      = f_decode(s_awaddr);
  assign w_ar_dec      = f_decode(s_araddr);
  assign wr_decerr_cnt = r_wr_cnt;
  assign rd_decerr_cnt = r_rd_cnt;

  // Holds both address readies low until the first edge after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- write path
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wstate <= W_IDLE;
      r_awaddr <= '0;
      r_wsel   <= '0;
      r_wmiss  <= 1'b0;
      r_wr_cnt <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (s_awvalid && s_awready) begin
        r_awaddr <= s_awaddr;
        r_wsel   <= w_aw_dec[SEL_W-1:0];
        r_wmiss  <= w_aw_dec[SEL_W];
      end
      if ((r_wstate == W_RESP) && r_wmiss && s_bready && (r_wr_cnt != C_CNT_MAX)) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_wstate_nxt  = r_wstate;
    s_awready     = 1'b0;
    s_wready      = 1'b0;
    s_bvalid      = 1'b0;
    s_bresp       = 2'b00;
    m_awvalid     = '0;
    m_awaddr      = '0;
    m_wvalid      = '0;
    m_wdata       = '0;
    m_wstrb       = '0;
    m_bready      = '0;
    w_sel_awready = 1'b0;
    w_sel_wready  = 1'b0;
    w_sel_bvalid  = 1'b0;
    w_sel_bresp   = 2'b00;

    for (int i = 0; i < N_SLV; i++) begin
      if (r_wsel == SEL_W'(i)) begin
        w_sel_awready = m_awready[i];
        w_sel_wready  = m_wready[i];
        w_sel_bvalid  = m_bvalid[i];
        w_sel_bresp   = m_bresp[2*i +: 2];
      end
    end

    case (r_wstate)
      W_IDLE: begin
        s_awready = r_rdy_en;
        if (s_awvalid && r_rdy_en) begin
          w_wstate_nxt = w_aw_dec[SEL_W] ? W_DATA : W_ADDR;
        end
      end
      W_ADDR: begin
        for (int i = 0; i < N_SLV; i++) begin
          if (r_wsel == SEL_W'(i)) begin
            m_awvalid[i]                 = 1'b1;
            m_awaddr[i*ADDR_W +: ADDR_W] = r_awaddr;
          end
        end
        if (w_sel_awready) begin
          w_wstate_nxt = W_DATA;
        end
      end
      W_DATA: begin
        if (r_wmiss) begin
          s_wready = 1'b1;
          if (s_wvalid) begin
            w_wstate_nxt = W_RESP;
          end
        end else begin
          for (int i = 0; i < N_SLV; i++) begin
            if (r_wsel == SEL_W'(i)) begin
              m_wvalid[i]                 = s_wvalid;
              m_wdata[i*DATA_W +: DATA_W] = s_wdata;
              m_wstrb[i*STRB_W +: STRB_W] = s_wstrb;
            end
          end
          s_wready = w_sel_wready;
          if (s_wvalid && w_sel_wready) begin
            w_wstate_nxt = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (r_wmiss) begin
          s_bvalid = 1'b1;
          s_bresp  = C_DECERR;
          if (s_bready) begin
            w_wstate_nxt = W_IDLE;
          end
        end else begin
          for (int i = 0; i < N_SLV; i++) begin
            if (r_wsel == SEL_W'(i)) begin
              m_bready[i] = s_bready;
            end
          end
          s_bvalid = w_sel_bvalid;
          s_bresp  = w_sel_bresp;
          if (w_sel_bvalid && s_bready) begin
            w_wstate_nxt = W_IDLE;
          end
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // ----------------------------------------------------------------- read path
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rstate <= R_IDLE;
      r_araddr <= '0;
      r_rsel   <= '0;
      r_rmiss  <= 1'b0;
      r_rd_cnt <= '0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (s_arvalid && s_arready) begin
        r_araddr <= s_araddr;
        r_rsel   <= w_ar_dec[SEL_W-1:0];
        r_rmiss  <= w_ar_dec[SEL_W];
      end
      if ((r_rstate == R_DATA) && r_rmiss && s_rready && (r_rd_cnt != C_CNT_MAX)) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_rstate_nxt  = r_rstate;
    s_arready     = 1'b0;
    s_rvalid      = 1'b0;
    s_rdata       = '0;
    s_rresp       = 2'b00;
    m_arvalid     = '0;
    m_araddr      = '0;
    m_rready      = '0;
    w_sel_arready = 1'b0;
    w_sel_rvalid  = 1'b0;
    w_sel_rresp   = 2'b00;
    w_sel_rdata   = '0;

    for (int i = 0; i < N_SLV; i++) begin
      if (r_rsel == SEL_W'(i)) begin
        w_sel_arready = m_arready[i];
        w_sel_rvalid  = m_rvalid[i];
        w_sel_rresp   = m_rresp[2*i +: 2];
        w_sel_rdata   = m_rdata[i*DATA_W +: DATA_W];
      end
    end

    case (r_rstate)
      R_IDLE: begin
        s_arready = r_rdy_en;
        if (s_arvalid && r_rdy_en) begin
          w_rstate_nxt = w_ar_dec[SEL_W] ? R_DATA : R_ADDR;
        end
      end
      R_ADDR: begin
        for (int i = 0; i < N_SLV; i++) begin
          if (r_rsel == SEL_W'(i)) begin
            m_arvalid[i]                 = 1'b1;
            m_araddr[i*ADDR_W +: ADDR_W] = r_araddr;
          end
        end
        if (w_sel_arready) begin
          w_rstate_nxt = R_DATA;
        end
      end
      R_DATA: begin
        if (r_rmiss) begin
          s_rvalid = 1'b1;
          s_rresp  = C_DECERR;
          if (s_rready) begin
            w_rstate_nxt = R_IDLE;
          end
        end else begin
          for (int i = 0; i < N_SLV; i++) begin
            if (r_rsel == SEL_W'(i)) begin
              m_rready[i] = s_rready;
            end
          end
          s_rvalid = w_sel_rvalid;
          s_rdata  = w_sel_rdata;
          s_rresp  = w_sel_rresp;
          if (w_sel_rvalid && s_rready) begin
            w_rstate_nxt = R_IDLE;
          end
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_addr_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_addr_router
// Brief    : Directed self-checking bench; default map plus a small overlap/top-of-space map.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_addr_router;

  logic aclk;
  logic aresetn;

  // instance A: default parameters
  logic [63:0]  a_s_awaddr;  logic a_s_awvalid, a_s_awready;
  logic [31:0]  a_s_wdata;   logic [3:0] a_s_wstrb; logic a_s_wvalid, a_s_wready;
  logic [1:0]   a_s_bresp;   logic a_s_bvalid, a_s_bready;
  logic [63:0]  a_s_araddr;  logic a_s_arvalid, a_s_arready;
  logic [31:0]  a_s_rdata;   logic [1:0] a_s_rresp; logic a_s_rvalid, a_s_rready;
  logic [255:0] a_m_awaddr;  logic [3:0] a_m_awvalid, a_m_awready;
  logic [127:0] a_m_wdata;   logic [15:0] a_m_wstrb; logic [3:0] a_m_wvalid, a_m_wready;
  logic [7:0]   a_m_bresp;   logic [3:0] a_m_bvalid, a_m_bready;
  logic [255:0] a_m_araddr;  logic [3:0] a_m_arvalid, a_m_arready;
  logic [127:0] a_m_rdata;   logic [7:0] a_m_rresp; logic [3:0] a_m_rvalid, a_m_rready;
  logic [15:0]  a_wr_cnt, a_rd_cnt;

  // instance B: overlapping regions, region at top of address space, 4-bit counters
  logic [63:0]  b_s_awaddr;  logic b_s_awvalid, b_s_awready;
  logic [31:0]  b_s_wdata;   logic [3:0] b_s_wstrb; logic b_s_wvalid, b_s_wready;
  logic [1:0]   b_s_bresp;   logic b_s_bvalid, b_s_bready;
  logic [63:0]  b_s_araddr;  logic b_s_arvalid, b_s_arready;
  logic [31:0]  b_s_rdata;   logic [1:0] b_s_rresp; logic b_s_rvalid, b_s_rready;
  logic [191:0] b_m_awaddr;  logic [2:0] b_m_awvalid, b_m_awready;
  logic [95:0]  b_m_wdata;   logic [11:0] b_m_wstrb; logic [2:0] b_m_wvalid, b_m_wready;
  logic [5:0]   b_m_bresp;   logic [2:0] b_m_bvalid, b_m_bready;
  logic [191:0] b_m_araddr;  logic [2:0] b_m_arvalid, b_m_arready;
  logic [95:0]  b_m_rdata;   logic [5:0] b_m_rresp; logic [2:0] b_m_rvalid, b_m_rready;
  logic [3:0]   b_wr_cnt, b_rd_cnt;

  int n_checks = 0;
  int n_errors = 0;

  axi_lite_addr_router u_dut_a (
    .aclk(aclk), .aresetn(aresetn),
    .s_awaddr(a_s_awaddr), .s_awvalid(a_s_awvalid), .s_awready(a_s_awready),
    .s_wdata(a_s_wdata), .s_wstrb(a_s_wstrb), .s_wvalid(a_s_wvalid), .s_wready(a_s_wready),
    .s_bresp(a_s_bresp), .s_bvalid(a_s_bvalid), .s_bready(a_s_bready),
    .s_araddr(a_s_araddr), .s_arvalid(a_s_arvalid), .s_arready(a_s_arready),
    .s_rdata(a_s_rdata), .s_rresp(a_s_rresp), .s_rvalid(a_s_rvalid), .s_rready(a_s_rready),
    .m_awaddr(a_m_awaddr), .m_awvalid(a_m_awvalid), .m_awready(a_m_awready),
    .m_wdata(a_m_wdata), .m_wstrb(a_m_wstrb), .m_wvalid(a_m_wvalid), .m_wready(a_m_wready),
    .m_bresp(a_m_bresp), .m_bvalid(a_m_bvalid), .m_bready(a_m_bready),
    .m_araddr(a_m_araddr), .m_arvalid(a_m_arvalid), .m_arready(a_m_arready),
    .m_rdata(a_m_rdata), .m_rresp(a_m_rresp), .m_rvalid(a_m_rvalid), .m_rready(a_m_rready),
    .wr_decerr_cnt(a_wr_cnt), .rd_decerr_cnt(a_rd_cnt)
  );

  axi_lite_addr_router #(
    .N_SLV(3), .ADDR_W(64), .DATA_W(32),
    .BASE_ADDRS({64'hFFFF_FFFF_FFFF_F000, 64'h0000_0000_0000_2000, 64'h0000_0000_0000_1000}),
    .RANGES({64'h1000, 64'h1000, 64'h2000}),
    .CNT_W(4)
  ) u_dut_b (
    .aclk(aclk), .aresetn(aresetn),
    .s_awaddr(b_s_awaddr), .s_awvalid(b_s_awvalid), .s_awready(b_s_awready),
    .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb), .s_wvalid(b_s_wvalid), .s_wready(b_s_wready),
    .s_bresp(b_s_bresp), .s_bvalid(b_s_bvalid), .s_bready(b_s_bready),
    .s_araddr(b_s_araddr), .s_arvalid(b_s_arvalid), .s_arready(b_s_arready),
    .s_rdata(b_s_rdata), .s_rresp(b_s_rresp), .s_rvalid(b_s_rvalid), .s_rready(b_s_rready),
    .m_awaddr(b_m_awaddr), .m_awvalid(b_m_awvalid), .m_awready(b_m_awready),
    .m_wdata(b_m_wdata), .m_wstrb(b_m_wstrb), .m_wvalid(b_m_wvalid), .m_wready(b_m_wready),
    .m_bresp(b_m_bresp), .m_bvalid(b_m_bvalid), .m_bready(b_m_bready),
    .m_araddr(b_m_araddr), .m_arvalid(b_m_arvalid), .m_arready(b_m_arready),
    .m_rdata(b_m_rdata), .m_rresp(b_m_rresp), .m_rvalid(b_m_rvalid), .m_rready(b_m_rready),
    .wr_decerr_cnt(b_wr_cnt), .rd_decerr_cnt(b_rd_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Read on instance B; exp_sel one-hot slave, 0 means an unmapped address.
  task automatic b_read(input string tag, input logic [63:0] addr, input logic [2:0] exp_sel);
    @(negedge aclk);
    b_s_araddr  = addr;
    b_s_arvalid = 1'b1;
    @(negedge aclk);
    b_s_arvalid = 1'b0;
    #1;
    check({tag, "_arvalid"}, 64'(b_m_arvalid), 64'(exp_sel));
    if (exp_sel != 3'b000) begin
      b_m_arready = exp_sel;
      @(negedge aclk);
      b_m_arready = 3'b000;
      b_m_rvalid  = exp_sel;
      b_m_rdata   = {3{32'h0BAD_CAFE}};
      b_s_rready  = 1'b1;
      #1;
      check({tag, "_rvalid"}, 64'(b_s_rvalid), 64'd1);
      check({tag, "_rdata"}, 64'(b_s_rdata), 64'h0BAD_CAFE);
      check({tag, "_rready"}, 64'(b_m_rready), 64'(exp_sel));
    end else begin
      b_s_rready = 1'b1;
      #1;
      check({tag, "_rresp"}, 64'(b_s_rresp), 64'h3);
      check({tag, "_rdata"}, 64'(b_s_rdata), 64'h0);
    end
    @(negedge aclk);
    b_m_rvalid = 3'b000;
    b_s_rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    aresetn = 1'b0;
    a_s_awaddr = '0; a_s_awvalid = 0; a_s_wdata = '0; a_s_wstrb = '0; a_s_wvalid = 0; a_s_bready = 0;
    a_s_araddr = '0; a_s_arvalid = 0; a_s_rready = 0;
    a_m_awready = '0; a_m_wready = '0; a_m_bresp = '0; a_m_bvalid = '0;
    a_m_arready = '0; a_m_rdata = '0; a_m_rresp = '0; a_m_rvalid = '0;
    b_s_awaddr = '0; b_s_awvalid = 0; b_s_wdata = '0; b_s_wstrb = '0; b_s_wvalid = 0; b_s_bready = 0;
    b_s_araddr = '0; b_s_arvalid = 0; b_s_rready = 0;
    b_m_awready = '0; b_m_wready = '0; b_m_bresp = '0; b_m_bvalid = '0;
    b_m_arready = '0; b_m_rdata = '0; b_m_rresp = '0; b_m_rvalid = '0;

    // ---- reset state
    repeat (3) @(negedge aclk);
    #1;
    check("rst_awready", 64'(a_s_awready), 64'd0);
    check("rst_arready", 64'(a_s_arready), 64'd0);
    check("rst_awvalid", 64'(a_m_awvalid), 64'd0);
    check("rst_bvalid", 64'(a_s_bvalid), 64'd0);
    check("rst_wr_cnt", 64'(a_wr_cnt), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("rel_awready_before_edge", 64'(a_s_awready), 64'd0);
    @(negedge aclk);
    #1;
    check("rel_awready", 64'(a_s_awready), 64'd1);
    check("rel_arready", 64'(a_s_arready), 64'd1);

    // ---- early W data is not consumed while idle
    a_s_wvalid = 1'b1;
    #1;
    check("early_w_wready", 64'(a_s_wready), 64'd0);
    a_s_wvalid = 1'b0;

    // ---- write to slave 2
    @(negedge aclk);
    a_s_awaddr  = 64'h0000_0202_0102_0004;
    a_s_awvalid = 1'b1;
    #1;
    check("wr2_awready", 64'(a_s_awready), 64'd1);
    @(negedge aclk);
    a_s_awvalid = 1'b0;
    #1;
    check("wr2_m_awvalid", 64'(a_m_awvalid), 64'h4);
    check("wr2_m_awaddr", a_m_awaddr[2*64 +: 64], 64'h0000_0202_0102_0004);
    check("wr2_other_awaddr", a_m_awaddr[0 +: 64], 64'h0);
    a_m_awready = 4'b0100;
    @(negedge aclk);
    a_m_awready = 4'b0000;
    a_s_wdata   = 32'hDEAD_BEEF;
    a_s_wstrb   = 4'hF;
    a_s_wvalid  = 1'b1;
    a_m_wready  = 4'b0100;
    #1;
    check("wr2_m_awvalid_drop", 64'(a_m_awvalid), 64'h0);
    check("wr2_m_wvalid", 64'(a_m_wvalid), 64'h4);
    check("wr2_m_wdata", 64'(a_m_wdata[2*32 +: 32]), 64'hDEAD_BEEF);
    check("wr2_s_wready", 64'(a_s_wready), 64'd1);
    @(negedge aclk);
    a_s_wvalid = 1'b0;
    a_m_wready = 4'b0000;
    a_m_bvalid = 4'b0100;
    a_m_bresp  = 8'h00;
    a_s_bready = 1'b1;
    #1;
    check("wr2_s_bvalid", 64'(a_s_bvalid), 64'd1);
    check("wr2_s_bresp", 64'(a_s_bresp), 64'd0);
    check("wr2_m_bready", 64'(a_m_bready), 64'h4);
    @(negedge aclk);
    a_m_bvalid = 4'b0000;
    a_s_bready = 1'b0;
    #1;
    check("wr2_idle_awready", 64'(a_s_awready), 64'd1);
    check("wr2_idle_bvalid", 64'(a_s_bvalid), 64'd0);

    // ---- read last word of slave 3
    @(negedge aclk);
    a_s_araddr  = 64'h0000_0202_0103_FFFC;
    a_s_arvalid = 1'b1;
    @(negedge aclk);
    a_s_arvalid = 1'b0;
    #1;
    check("rd3_m_arvalid", 64'(a_m_arvalid), 64'h8);
    check("rd3_m_araddr", a_m_araddr[3*64 +: 64], 64'h0000_0202_0103_FFFC);
    a_m_arready = 4'b1000;
    @(negedge aclk);
    a_m_arready = 4'b0000;
    a_m_rvalid  = 4'b1000;
    a_m_rdata   = {32'h1234_5678, 96'h0};
    a_m_rresp   = 8'h00;
    a_s_rready  = 1'b1;
    #1;
    check("rd3_s_rvalid", 64'(a_s_rvalid), 64'd1);
    check("rd3_s_rdata", 64'(a_s_rdata), 64'h1234_5678);
    check("rd3_m_rready", 64'(a_m_rready), 64'h8);
    @(negedge aclk);
    a_m_rvalid = 4'b0000;
    a_s_rready = 1'b0;

    // ---- unmapped read just past slave 3
    @(negedge aclk);
    a_s_araddr  = 64'h0000_0202_0104_0000;
    a_s_arvalid = 1'b1;
    @(negedge aclk);
    a_s_arvalid = 1'b0;
    #1;
    check("rdmiss_m_arvalid", 64'(a_m_arvalid), 64'h0);
    check("rdmiss_s_rvalid", 64'(a_s_rvalid), 64'd1);
    check("rdmiss_s_rdata", 64'(a_s_rdata), 64'h0);
    check("rdmiss_s_rresp", 64'(a_s_rresp), 64'h3);
    check("rdmiss_cnt_before", 64'(a_rd_cnt), 64'd0);
    a_s_rready = 1'b1;
    @(negedge aclk);
    a_s_rready = 1'b0;
    #1;
    check("rdmiss_cnt_after", 64'(a_rd_cnt), 64'd1);
    check("rdmiss_s_rvalid_drop", 64'(a_s_rvalid), 64'd0);

    // ---- concurrent write slave 0 / read slave 1 with 5-cycle address stall
    @(negedge aclk);
    a_s_awaddr  = 64'h0000_0202_0100_0010;
    a_s_awvalid = 1'b1;
    a_s_araddr  = 64'h0000_0202_0101_0020;
    a_s_arvalid = 1'b1;
    #1;
    check("cc_awready", 64'(a_s_awready), 64'd1);
    check("cc_arready", 64'(a_s_arready), 64'd1);
    @(negedge aclk);
    a_s_awvalid = 1'b0;
    a_s_arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("cc_stall_awvalid", 64'(a_m_awvalid), 64'h1);
      check("cc_stall_arvalid", 64'(a_m_arvalid), 64'h2);
      check("cc_stall_awaddr", a_m_awaddr[0 +: 64], 64'h0000_0202_0100_0010);
      check("cc_stall_araddr", a_m_araddr[64 +: 64], 64'h0000_0202_0101_0020);
      @(negedge aclk);
    end
    a_m_awready = 4'b0001;
    a_m_arready = 4'b0010;
    #1;
    check("cc_hs_awvalid", 64'(a_m_awvalid), 64'h1);
    check("cc_hs_arvalid", 64'(a_m_arvalid), 64'h2);
    @(negedge aclk);
    a_m_awready = 4'b0000;
    a_m_arready = 4'b0000;
    a_s_wdata   = 32'hCAFE_F00D;
    a_s_wstrb   = 4'h3;
    a_s_wvalid  = 1'b1;
    a_m_wready  = 4'b0001;
    a_m_rvalid  = 4'b0010;
    a_m_rdata   = {64'h0, 32'hA5A5_5A5A, 32'h0};
    a_m_rresp   = 8'h00;
    a_s_rready  = 1'b1;
    #1;
    check("cc_m_wvalid", 64'(a_m_wvalid), 64'h1);
    check("cc_m_wdata", 64'(a_m_wdata[0 +: 32]), 64'hCAFE_F00D);
    check("cc_m_wstrb", 64'(a_m_wstrb[0 +: 4]), 64'h3);
    check("cc_s_rvalid", 64'(a_s_rvalid), 64'd1);
    check("cc_s_rdata", 64'(a_s_rdata), 64'hA5A5_5A5A);
    @(negedge aclk);
    a_s_wvalid = 1'b0;
    a_m_wready = 4'b0000;
    a_m_rvalid = 4'b0000;
    a_s_rready = 1'b0;
    a_m_bvalid = 4'b0001;
    a_m_bresp  = 8'b0000_0010;
    a_s_bready = 1'b1;
    #1;
    check("cc_s_bvalid", 64'(a_s_bvalid), 64'd1);
    check("cc_s_bresp", 64'(a_s_bresp), 64'h2);
    check("cc_m_bready", 64'(a_m_bready), 64'h1);
    check("cc_s_rvalid_done", 64'(a_s_rvalid), 64'd0);
    @(negedge aclk);
    a_m_bvalid = 4'b0000;
    a_m_bresp  = 8'h00;
    a_s_bready = 1'b0;

    // ---- instance B: 20 unmapped writes into a 4-bit counter
    for (int n = 0; n < 20; n++) begin
      @(negedge aclk);
      b_s_awaddr  = 64'h8000;
      b_s_awvalid = 1'b1;
      @(negedge aclk);
      b_s_awvalid = 1'b0;
      b_s_wdata   = 32'(n);
      b_s_wstrb   = 4'hF;
      b_s_wvalid  = 1'b1;
      #1;
      check("wmiss_s_wready", 64'(b_s_wready), 64'd1);
      check("wmiss_m_wvalid", 64'(b_m_wvalid), 64'h0);
      @(negedge aclk);
      b_s_wvalid = 1'b0;
      b_s_bready = 1'b1;
      #1;
      check("wmiss_s_bresp", 64'(b_s_bresp), 64'h3);
      check("wmiss_s_bvalid", 64'(b_s_bvalid), 64'd1);
      @(negedge aclk);
      b_s_bready = 1'b0;
      if (n == 14) begin
        #1;
        check("wmiss_cnt_15", 64'(b_wr_cnt), 64'd15);
      end
    end
    #1;
    check("wmiss_cnt_sat", 64'(b_wr_cnt), 64'd15);

    // ---- instance B: overlap priority and top-of-space region
    b_read("overlap_2800", 64'h2800, 3'b001);
    b_read("overlap_1000", 64'h1000, 3'b001);
    b_read("top_fff0", 64'hFFFF_FFFF_FFFF_FFF0, 3'b100);
    b_read("top_miss_0", 64'h0, 3'b000);
    #1;
    check("top_miss_rd_cnt", 64'(b_rd_cnt), 64'd1);

    // ---- asynchronous reset during an address phase
    @(negedge aclk);
    a_s_awaddr  = 64'h0000_0202_0101_0000;
    a_s_awvalid = 1'b1;
    @(negedge aclk);
    a_s_awvalid = 1'b0;
    #1;
    check("arst_m_awvalid_pre", 64'(a_m_awvalid), 64'h2);
    #2;
    aresetn = 1'b0;
    #1;
    check("arst_m_awvalid", 64'(a_m_awvalid), 64'h0);
    check("arst_awready", 64'(a_s_awready), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    #1;
    check("arst_rel_awready", 64'(a_s_awready), 64'd1);
    check("arst_rel_rd_cnt", 64'(a_rd_cnt), 64'd0);
    check("arst_rel_m_awvalid", 64'(a_m_awvalid), 64'h0);
    a_s_bready = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      #1;
      check("arst_no_bvalid", 64'(a_s_bvalid), 64'd0);
    end
    a_s_bready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
